// File: rtl/multicycle_stall_ctrl.sv
// Stall controller for multi-cycle EX operations (MULT/DIV): launches the unit, freezes the
// PC and selected pipeline registers until the op completes, then releases for one cycle.
module multicycle_stall_ctrl #(
    parameter int unsigned           NUM_STAGES = 4,
    parameter logic [NUM_STAGES-1:0] HOLD_MASK  = {NUM_STAGES{1'b1}},
    parameter logic [3:0]            MULT_CODE  = 4'b1111,
    parameter logic [3:0]            DIV_CODE   = 4'b1110,
    parameter int unsigned           MULT_LAT   = 3,
    parameter int unsigned           DIV_LAT    = 16,
    parameter int unsigned           CNT_W      = 5,
    parameter bit                    HS_MODE    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_valid,
    input  logic [3:0]            aluCtrl,
    input  logic                  flush,
    input  logic                  unit_done,
    output logic                  pc_en,
    output logic [NUM_STAGES-1:0] stage_hold,
    output logic                  unit_start,
    output logic                  unit_is_div,
    output logic                  result_valid,
    output logic                  busy,
    output logic [31:0]           perf_stall_cnt
);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBusy = 2'b01,
        StDone = 2'b10,
        StBad  = 2'b11
    } state_e;

    // The start cycle is one stall cycle and the cnt==0 BUSY cycle is another.
    localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_LAT - 2);
    localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_LAT - 2);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_div_q, is_div_d;
    logic [31:0]       perf_q, perf_d;
    logic              hit, hit_div, stall;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_div_d     = is_div_q;
        stall        = 1'b0;
        unit_start   = 1'b0;
        result_valid = 1'b0;
        hit_div      = (aluCtrl == DIV_CODE);
        hit          = ex_valid & ((aluCtrl == MULT_CODE) | hit_div);

        case (state_q)
            StIdle: begin
                if (hit && !flush) begin
                    stall      = 1'b1;
                    unit_start = 1'b1;
                    is_div_d   = hit_div;
                    cnt_d      = hit_div ? DivLoad : MultLoad;
                    state_d    = StBusy;
                end
            end
            StBusy: begin
                if (flush) begin
                    state_d = StIdle;
                end else begin
                    stall = 1'b1;
                    if (HS_MODE) begin
                        if (unit_done) state_d = StDone;
                    end else if (cnt_q == '0) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            // aluCtrl is not decoded here so the completed op cannot re-trigger.
            StDone: begin
                result_valid = 1'b1;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // State is already IDLE under reset, but a hit in EX must not stall.
        if (rst) begin
            stall        = 1'b0;
            unit_start   = 1'b0;
            result_valid = 1'b0;
        end

        pc_en      = ~stall;
        busy       = stall;
        stage_hold = stall ? HOLD_MASK : '0;
        perf_d     = (stall && (perf_q != 32'hFFFF_FFFF)) ? perf_q + 32'd1 : perf_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            perf_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            perf_q   <= perf_d;
        end
    end

    assign unit_is_div    = is_div_q;
    assign perf_stall_cnt = perf_q;

endmodule

// File: tb/tb_multicycle_stall_ctrl.sv
// Randomized scoreboard bench: two controllers (fixed-count and handshake mode) share stimulus
// and are checked every cycle against an age/length model of the op in flight.
module tb_multicycle_stall_ctrl;

    localparam logic [3:0] MULT     = 4'hF;
    localparam logic [3:0] DIV      = 4'hE;
    localparam int         MULT_LAT = 3;
    localparam int         DIV_LAT  = 16;
    localparam int         NEVER    = 1 << 30;

    logic       clk = 1'b0;
    logic       rst, ex_valid, flush, unit_done;
    logic [3:0] aluCtrl;

    logic        pc_en0, start0, div0, rv0, busy0;
    logic [3:0]  hold0;
    logic [31:0] perf0;
    logic        pc_en1, start1, div1, rv1, busy1;
    logic [3:0]  hold1;
    logic [31:0] perf1;

    always #5 clk = ~clk;

    multicycle_stall_ctrl #(.HS_MODE(1'b0)) dut_cnt (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .aluCtrl(aluCtrl), .flush(flush),
        .unit_done(unit_done), .pc_en(pc_en0), .stage_hold(hold0), .unit_start(start0),
        .unit_is_div(div0), .result_valid(rv0), .busy(busy0), .perf_stall_cnt(perf0)
    );

    multicycle_stall_ctrl #(.HS_MODE(1'b1)) dut_hs (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .aluCtrl(aluCtrl), .flush(flush),
        .unit_done(unit_done), .pc_en(pc_en1), .stage_hold(hold1), .unit_start(start1),
        .unit_is_div(div1), .result_valid(rv1), .busy(busy1), .perf_stall_cnt(perf1)
    );

    // One op in flight: age counts cycles since its start, len is the cycle it completes on.
    typedef struct {
        bit     active;
        int     age;
        int     len;
        bit     is_div;
        longint perf;
    } model_t;

    typedef struct packed {
        logic        pc_en;
        logic [3:0]  hold;
        logic        start;
        logic        is_div;
        logic        rv;
        logic        busy;
        logic [31:0] perf;
    } exp_t;

    model_t m0, m1;
    exp_t   q0[$];
    exp_t   q1[$];
    int     vectors = 0;
    int     miscompares = 0;
    int     cyc = 0;

    task automatic step(inout model_t m, input bit hs, output exp_t e);
        bit stall;
        stall    = 1'b0;
        e        = '0;
        e.pc_en  = 1'b1;
        e.is_div = m.is_div;
        e.perf   = m.perf[31:0];
        if (rst) begin
            m.active = 1'b0;
            m.age    = 0;
            m.len    = 0;
            m.is_div = 1'b0;
            m.perf   = 0;
            e.is_div = 1'b0;
            e.perf   = '0;
            return;
        end
        if (m.active && m.age == m.len) begin
            e.rv     = 1'b1;
            m.active = 1'b0;
        end else if (m.active) begin
            if (flush) begin
                m.active = 1'b0;
            end else begin
                stall = 1'b1;
                if (hs && unit_done) m.len = m.age + 1;
                m.age++;
            end
        end else if (ex_valid && (aluCtrl == MULT || aluCtrl == DIV) && !flush) begin
            stall    = 1'b1;
            e.start  = 1'b1;
            m.is_div = (aluCtrl == DIV);
            m.active = 1'b1;
            m.age    = 1;
            m.len    = hs ? NEVER : (m.is_div ? DIV_LAT : MULT_LAT);
        end
        e.pc_en = !stall;
        e.busy  = stall;
        e.hold  = stall ? 4'hF : 4'h0;
        if (stall && m.perf < 64'hFFFF_FFFF) m.perf++;
    endtask

    task automatic drive(input bit r, input bit ev, input logic [3:0] op, input bit fl,
                         input bit ud);
        exp_t e0, e1;
        @(posedge clk);
        #1;
        rst       = r;
        ex_valid  = ev;
        aluCtrl   = op;
        flush     = fl;
        unit_done = ud;
        step(m0, 1'b0, e0);
        step(m1, 1'b1, e1);
        q0.push_back(e0);
        q1.push_back(e1);
        cyc++;
    endtask

    task automatic check(input string name, input exp_t act, input exp_t exp);
        vectors++;
        if (act[40:32] !== exp[40:32]) begin
            miscompares++;
            $display("FAIL %s ctrl cycle %0d: pc_en,hold,start,div,rv,busy got %b want %b",
                     name, cyc, act[40:32], exp[40:32]);
        end
        vectors++;
        if (act.perf !== exp.perf) begin
            miscompares++;
            $display("FAIL %s perf_stall_cnt cycle %0d: got %0d want %0d",
                     name, cyc, act.perf, exp.perf);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("count_mode", {pc_en0, hold0, start0, div0, rv0, busy0, perf0}, e);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("hs_mode", {pc_en1, hold1, start1, div1, rv1, busy1, perf1}, e);
        end
    end

    initial begin
        logic [3:0] op;
        rst       = 1'b1;
        ex_valid  = 1'b0;
        aluCtrl   = 4'h0;
        flush     = 1'b0;
        unit_done = 1'b0;
        m0        = '{default: 0};
        m1        = '{default: 0};

        repeat (2) drive(1, 0, 4'h0, 0, 0);
        // Early unit_done in IDLE, then a held MULT (back-to-back in count mode).
        drive(0, 0, 4'h0, 0, 1);
        repeat (6) drive(0, 1, MULT, 0, 0);
        repeat (6) drive(0, 0, 4'h0, 0, 0);
        drive(0, 0, 4'h0, 0, 1);
        repeat (3) drive(0, 0, 4'h0, 0, 0);
        // Held DIV for the full count, then release.
        repeat (18) drive(0, 1, DIV, 0, 0);
        repeat (3) drive(0, 0, 4'h0, 0, 1);
        // Flush in the second BUSY cycle.
        repeat (2) drive(0, 1, MULT, 0, 0);
        drive(0, 1, MULT, 1, 0);
        repeat (3) drive(0, 0, 4'h0, 0, 0);
        // Reset mid-DIV with a hit still present.
        repeat (5) drive(0, 1, DIV, 0, 0);
        drive(1, 1, DIV, 0, 0);
        repeat (3) drive(0, 0, 4'h0, 0, 0);

        for (int i = 0; i < 4000; i++) begin
            case ($urandom_range(0, 3))
                0:       op = MULT;
                1:       op = DIV;
                default: op = 4'($urandom_range(0, 15));
            endcase
            drive($urandom_range(0, 299) == 0, $urandom_range(0, 3) != 0, op,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0);
        end
        drive(0, 0, 4'h0, 0, 0);
        @(negedge clk);
        #1;
        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d/%0d pending records want 0/0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
